// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard/forwarding unit
//
// Contents:
//   fwd_sel_t : EX operand mux select (register file, MEM/WB, EX/MEM, long-latency)
//   REG_ZERO  : architectural x0 index, never tracked and never forwarded
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10,
        FWD_LL    = 2'b11
    } fwd_sel_t;

    localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-register scoreboard for long-latency destinations
//
// Parameters:
//   REG_AW  : register address width, 2**REG_AW tracked registers
//   NUM_RD  : number of pending-lookup ports
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   set_en_i/set_rd_i : mark a destination as in flight (x0 ignored)
//   clr_en_i/clr_rd_i : long-latency writeback releasing a destination
//   rd_addr_i      : packed lookup addresses, port k at [k*REG_AW +: REG_AW]
//   pend_o         : per-port pending flag, already excluding this cycle's writeback
//   busy_o         : any register in flight
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int NUM_RD = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     set_en_i,
    input  logic [REG_AW-1:0]        set_rd_i,
    input  logic                     clr_en_i,
    input  logic [REG_AW-1:0]        clr_rd_i,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        pend_o,
    output logic                     busy_o
);

    localparam int DEPTH = 1 << REG_AW;
    localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

    logic [DEPTH-1:0] sb_q;
    logic [DEPTH-1:0] sb_d;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;

    // Set is applied after clear so a re-issue to a register that is being
    // written back in the same cycle stays tracked for the new producer.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en_i && (set_rd_i != RZ)) begin
            set_vec[set_rd_i] = 1'b1;
        end
        if (clr_en_i) begin
            clr_vec[clr_rd_i] = 1'b1;
        end
        sb_d = (sb_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // Same-cycle release: a writeback this cycle already un-blocks its readers.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_pend
        logic [REG_AW-1:0] addr;
        assign addr      = rd_addr_i[k*REG_AW +: REG_AW];
        assign pend_o[k] = sb_q[addr] && !(clr_en_i && (clr_rd_i == addr));
    end

    assign busy_o = |sb_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX operand forwarding and ID-stage hazard stall generation
//
// Parameters:
//   NUM_SRC : source operands per instruction (1..3)
//   REG_AW  : register address width
//   CNT_W   : stall performance counter width
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   if_id_rs_i, id_regwrite_i, id_rd_i, ll_issue_i : ID-stage instruction
//   id_ex_rs_i, id_ex_memread_i, id_ex_rd_i        : EX-stage instruction
//   ex_mem_*, mem_wb_*      : later-stage writeback candidates
//   ll_wb_valid_i/ll_wb_rd_i: long-latency unit writeback
//   perf_clr_i              : clear stall counter
//   fwd_sel_o               : per-operand select, operand k at [2k +: 2]
//   stall_o                 : hold PC and IF/ID, bubble ID/EX
//   ll_busy_o               : long-latency result outstanding
//   stall_cnt_o             : saturating stalled-cycle count
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_SRC*REG_AW-1:0] if_id_rs_i,
    input  logic                      id_regwrite_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs_i,
    input  logic                      id_ex_memread_i,
    input  logic [REG_AW-1:0]         id_ex_rd_i,
    input  logic                      ex_mem_regwrite_i,
    input  logic [REG_AW-1:0]         ex_mem_rd_i,
    input  logic                      mem_wb_regwrite_i,
    input  logic [REG_AW-1:0]         mem_wb_rd_i,
    input  logic                      ll_issue_i,
    input  logic                      ll_wb_valid_i,
    input  logic [REG_AW-1:0]         ll_wb_rd_i,
    input  logic                      perf_clr_i,
    output logic [2*NUM_SRC-1:0]      fwd_sel_o,
    output logic                      stall_o,
    output logic                      ll_busy_o,
    output logic [CNT_W-1:0]          stall_cnt_o
);

    localparam logic [REG_AW-1:0] RZ = REG_AW'(REG_ZERO);

    // Long-latency writeback of the previous cycle; the datapath keeps the
    // matching data register so the result can be forwarded one cycle later.
    logic              llq_valid;
    logic [REG_AW-1:0] llq_rd;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            llq_valid <= 1'b0;
            llq_rd    <= '0;
        end else begin
            llq_valid <= ll_wb_valid_i;
            llq_rd    <= ll_wb_rd_i;
        end
    end

    // Forward muxes: youngest producer wins, long-latency result last.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        logic [REG_AW-1:0] rs;
        fwd_sel_t          sel;

        assign rs = id_ex_rs_i[k*REG_AW +: REG_AW];

        always_comb begin
            sel = FWD_RF;
            if (rs == RZ) begin
                sel = FWD_RF;
            end else if (ex_mem_regwrite_i && (ex_mem_rd_i == rs)) begin
                sel = FWD_EXMEM;
            end else if (mem_wb_regwrite_i && (mem_wb_rd_i == rs)) begin
                sel = FWD_MEMWB;
            end else if (llq_valid && (llq_rd == rs)) begin
                sel = FWD_LL;
            end
        end

        assign fwd_sel_o[2*k +: 2] = sel;
    end

    // Scoreboard lookups: ports 0..NUM_SRC-1 are the ID sources, the last port
    // is the ID destination for the WAW check.
    logic [NUM_SRC:0] pend;
    logic             sb_set_en;

    assign sb_set_en = ll_issue_i && !stall_o;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .NUM_RD (NUM_SRC + 1)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .set_en_i  (sb_set_en),
        .set_rd_i  (id_rd_i),
        .clr_en_i  (ll_wb_valid_i),
        .clr_rd_i  (ll_wb_rd_i),
        .rd_addr_i ({id_rd_i, if_id_rs_i}),
        .pend_o    (pend),
        .busy_o    (ll_busy_o)
    );

    logic [NUM_SRC-1:0] load_use_hit;
    logic [NUM_SRC-1:0] raw_hit;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_haz
        logic [REG_AW-1:0] rs;
        assign rs              = if_id_rs_i[k*REG_AW +: REG_AW];
        assign load_use_hit[k] = id_ex_memread_i && (id_ex_rd_i != RZ) && (id_ex_rd_i == rs);
        assign raw_hit[k]      = (rs != RZ) && pend[k];
    end

    logic waw_hit;
    assign waw_hit = id_regwrite_i && (id_rd_i != RZ) && pend[NUM_SRC];

    assign stall_o = (|load_use_hit) || (|raw_hit) || waw_hit;

    // Stalled-cycle counter, saturating; clear has priority over increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule
